// File: rtl/posit_accum_8.sv
// Streaming posit accumulator: sums batches of 8 posit operands in an extended
// float accumulator and rounds once to an N-bit posit at the end of each batch.
module posit_accum_8 #(
  parameter int N  = 32,
  parameter int es = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in,
  output logic [N-1:0] result,
  output logic         inf,
  output logic         zero,
  output logic         done
);

  localparam int SW   = 10;                     // signed scale width
  localparam int MW   = N + 1 - es;             // hidden + fraction + 3 guard bits
  localparam int WW   = 2 * N + 8;              // encode staging width
  localparam int PADP = WW - 2 - es - (MW - 1);
  localparam int PADN = WW - 1 - es - (MW - 1);
  localparam logic signed [SW-1:0] MAX_SCALE = SW'((N - 2) * (1 << es));
  localparam logic signed [SW-1:0] MIN_SCALE = -MAX_SCALE;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, ENC} state_t;

  state_t                state_reg;
  logic [2:0]            count_reg;
  logic [N-1:0]          op_reg;
  logic                  op_valid_reg;
  logic                  nar_reg;
  logic                  acc_sign_reg, acc_sign_next;
  logic signed [SW-1:0]  acc_scale_reg, acc_scale_next;
  logic [MW-1:0]         acc_mag_reg, acc_mag_next;
  logic                  acc_sticky_reg, acc_sticky_next;
  logic [N-1:0]          result_reg;
  logic                  inf_reg, zero_reg, done_reg;

  function automatic logic [6:0] lzc_body(input logic [N-2:0] v);
    logic [6:0] r;
    r = 7'(N - 1);
    for (int i = 0; i < N - 1; i++)
      if (v[i]) r = 7'(N - 2 - i);
    return r;
  endfunction

  function automatic logic [6:0] lzc_mag(input logic [MW-1:0] v);
    logic [6:0] r;
    r = 7'(MW);
    for (int i = 0; i < MW; i++)
      if (v[i]) r = 7'(MW - 1 - i);
    return r;
  endfunction

  // Operand decode: regime run gives k, then es exponent bits, then fraction.
  logic                 op_sign, op_is_zero, op_is_nar;
  logic [N-2:0]         op_body, op_run, op_rem;
  logic [6:0]           op_m;
  logic signed [SW-1:0] op_k, op_scale;
  logic [MW-1:0]        op_mag;

  always_comb begin
    op_is_zero = (op_reg == '0);
    op_is_nar  = (op_reg == {1'b1, {(N-1){1'b0}}});
    op_sign    = op_reg[N-1];
    op_body    = op_sign ? (~op_reg[N-2:0] + (N-1)'(1)) : op_reg[N-2:0];
    op_run     = op_body[N-2] ? ~op_body : op_body;
    op_m       = lzc_body(op_run);
    op_k       = op_body[N-2] ? ($signed(SW'(op_m)) - SW'(1)) : -$signed(SW'(op_m));
    op_rem     = op_body << (op_m + 7'd1);
    op_scale   = (op_k <<< es) + $signed(SW'(op_rem[N-2 -: es]));
    // The two lowest remainder bits are always zero, so they land in the guard field.
    op_mag     = {1'b1, op_rem[N-2-es:0], 1'b0};
  end

  // Accumulate: align the smaller-scale term, add/subtract, renormalise.
  logic                 acc_big, big_sign, same_sign, lost;
  logic signed [SW-1:0] big_scale, small_scale;
  logic [MW-1:0]        big_mag, small_mag, small_al;
  logic [SW-1:0]        shift_d;
  logic [6:0]           shift_c, sum_lz;
  logic [2*MW-1:0]      align;
  logic [MW:0]          sum;

  always_comb begin
    acc_big     = (acc_scale_reg > op_scale) ||
                  ((acc_scale_reg == op_scale) && (acc_mag_reg >= op_mag));
    big_sign    = acc_big ? acc_sign_reg  : op_sign;
    big_scale   = acc_big ? acc_scale_reg : op_scale;
    small_scale = acc_big ? op_scale      : acc_scale_reg;
    big_mag     = acc_big ? acc_mag_reg   : op_mag;
    small_mag   = acc_big ? op_mag        : acc_mag_reg;
    same_sign   = (acc_sign_reg == op_sign);
    shift_d     = big_scale - small_scale;
    shift_c     = (shift_d > SW'(MW)) ? 7'(MW) : shift_d[6:0];
    align       = {small_mag, {MW{1'b0}}} >> shift_c;
    small_al    = align[2*MW-1:MW];
    lost        = |align[MW-1:0];
    sum         = same_sign ? ({1'b0, big_mag} + {1'b0, small_al})
                            : ({1'b0, big_mag} - {1'b0, small_al});
    sum_lz      = lzc_mag(sum[MW-1:0]);

    acc_sign_next   = acc_sign_reg;
    acc_scale_next  = acc_scale_reg;
    acc_mag_next    = acc_mag_reg;
    acc_sticky_next = acc_sticky_reg;
    if (op_valid_reg && !op_is_zero && !op_is_nar) begin
      if (acc_mag_reg == '0) begin
        acc_sign_next   = op_sign;
        acc_scale_next  = op_scale;
        acc_mag_next    = op_mag;
        acc_sticky_next = 1'b0;
      end else if (sum[MW]) begin
        acc_sign_next   = big_sign;
        acc_scale_next  = big_scale + SW'(1);
        acc_mag_next    = sum[MW:1];
        acc_sticky_next = acc_sticky_reg | lost | sum[0];
      end else if (sum[MW-1:0] == '0) begin
        acc_sign_next   = 1'b0;
        acc_scale_next  = '0;
        acc_mag_next    = '0;
        acc_sticky_next = 1'b0;
      end else begin
        acc_sign_next   = big_sign;
        acc_scale_next  = big_scale - $signed(SW'(sum_lz));
        acc_mag_next    = sum[MW-1:0] << sum_lz;
        acc_sticky_next = acc_sticky_reg | lost;
      end
    end
  end

  // Encode: lay out regime/exponent/fraction as a bit string, then round RNE.
  logic signed [SW-1:0] enc_k, enc_nk;
  logic [es-1:0]        enc_e;
  logic [WW-1:0]        enc_w;
  logic [N-2:0]         enc_p, enc_body;
  logic                 enc_g, enc_st, enc_up;
  logic [N-1:0]         enc_pr, enc_word;

  always_comb begin
    enc_k  = acc_scale_reg >>> es;
    enc_nk = -enc_k;
    enc_e  = acc_scale_reg[es-1:0];
    if (!enc_k[SW-1])
      enc_w = $signed({2'b10, enc_e, acc_mag_reg[MW-2:0], {PADP{1'b0}}}) >>> enc_k;
    else
      enc_w = {1'b1, enc_e, acc_mag_reg[MW-2:0], {PADN{1'b0}}} >> enc_nk;
    enc_p  = enc_w[WW-1 -: N-1];
    enc_g  = enc_w[WW-N];
    enc_st = (|enc_w[WW-N-1:0]) | acc_sticky_reg;
    enc_up = enc_g & (enc_st | enc_p[0]);
    enc_pr = {1'b0, enc_p} + N'(enc_up);
    enc_body = enc_pr[N-1] ? '1 : enc_pr[N-2:0];
    if (acc_scale_reg > MAX_SCALE)      enc_body = '1;
    else if (acc_scale_reg < MIN_SCALE) enc_body = (N-1)'(1);
    else if (enc_body == '0)            enc_body = (N-1)'(1);
    if (acc_mag_reg == '0)
      enc_word = '0;
    else
      enc_word = acc_sign_reg ? (~{1'b0, enc_body} + N'(1)) : {1'b0, enc_body};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      op_reg         <= '0;
      op_valid_reg   <= 1'b0;
      nar_reg        <= 1'b0;
      acc_sign_reg   <= 1'b0;
      acc_scale_reg  <= '0;
      acc_mag_reg    <= '0;
      acc_sticky_reg <= 1'b0;
      result_reg     <= '0;
      inf_reg        <= 1'b0;
      zero_reg       <= 1'b1;
      done_reg       <= 1'b0;
    end else begin
      done_reg       <= 1'b0;
      acc_sign_reg   <= acc_sign_next;
      acc_scale_reg  <= acc_scale_next;
      acc_mag_reg    <= acc_mag_next;
      acc_sticky_reg <= acc_sticky_next;
      if (op_valid_reg && op_is_nar) nar_reg <= 1'b1;
      case (state_reg)
        IDLE: if (start) begin
          op_reg       <= in;
          op_valid_reg <= 1'b1;
          count_reg    <= 3'd1;
          state_reg    <= ACC;
        end
        ACC: begin
          op_reg       <= in;
          op_valid_reg <= 1'b1;
          count_reg    <= count_reg + 3'd1;
          if (count_reg == 3'd7) state_reg <= DRAIN;
        end
        // The last captured term is added on this edge.
        DRAIN: begin
          op_valid_reg <= 1'b0;
          state_reg    <= ENC;
        end
        ENC: begin
          result_reg     <= nar_reg ? {1'b1, {(N-1){1'b0}}} : enc_word;
          inf_reg        <= nar_reg;
          zero_reg       <= !nar_reg && (enc_word == '0);
          done_reg       <= 1'b1;
          nar_reg        <= 1'b0;
          acc_sign_reg   <= 1'b0;
          acc_scale_reg  <= '0;
          acc_mag_reg    <= '0;
          acc_sticky_reg <= 1'b0;
          count_reg      <= '0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign result = result_reg;
  assign inf    = inf_reg;
  assign zero   = zero_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_posit_accum_8.sv
// Scoreboard bench for posit_accum_8: driver pushes hand-computed batch results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_posit_accum_8;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] in_w;
  logic [31:0] result;
  logic        inf, zero, done;

  always #5 clk = ~clk;

  posit_accum_8 #(.N(32), .es(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in_w),
    .result(result), .inf(inf), .zero(zero), .done(done)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        inf;
    logic        zero;
    bit          any_nz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0, miscompares = 0, cyc = 0, dones = 0;
  logic [31:0] ops [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      dones++;
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL spurious_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        $display("batch %-8s result=%08h inf=%0b zero=%0b cycle=%0d", e.name, result, inf, zero, cyc);
        vectors++;
        if (e.any_nz ? (result == 32'h0 || result == 32'h80000000) : (result !== e.res)) begin
          miscompares++;
          $display("FAIL %s.result: got %08h, required %s%08h", e.name, result,
                   e.any_nz ? "nonzero non-NaR, not " : "", e.any_nz ? 32'h0 : e.res);
        end
        vectors++;
        if (inf !== e.inf || zero !== e.zero) begin
          miscompares++;
          $display("FAIL %s.flags: got inf=%0b zero=%0b, required inf=%0b zero=%0b",
                   e.name, inf, zero, e.inf, e.zero);
        end
        vectors++;
        if (cyc != e.due) begin
          miscompares++;
          $display("FAIL %s.latency: done at cycle %0d, required %0d", e.name, cyc, e.due);
        end
      end
    end
  end

  task automatic run_batch(input string name, input logic [31:0] er, input logic ei,
                           input logic ez, input bit anz, input bit hold);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    in_w  = ops[0];
    e.name = name; e.res = er; e.inf = ei; e.zero = ez; e.any_nz = anz;
    e.due  = cyc + 10;
    sb.push_back(e);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      in_w = ops[i];
    end
    @(negedge clk); in_w = 32'hDEADBEEF;
    @(negedge clk);
  endtask

  task automatic drain();
    start = 1'b0;
    for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d batches without done, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %08h, required %08h", name, got, req);
    end
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; in_w = 32'h0;
    repeat (3) @(negedge clk);
    check("reset.result", result, 32'h0);
    check("reset.zero", {31'b0, zero}, 32'h1);
    check("reset.inf", {31'b0, inf}, 32'h0);
    check("reset.done", {31'b0, done}, 32'h0);
    rst = 1'b1;

    // start low: must stay idle
    d0 = dones;
    in_w = 32'h40000000;
    repeat (15) @(negedge clk);
    check("idle.no_done", dones, d0);

    ops = '{8{32'h40000000}};
    run_batch("one_x8", 32'h58000000, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    ops = '{8{32'h38000000}};
    run_batch("half_x8", 32'h50000000, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    ops = '{32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000,
            32'h40000000, 32'hC0000000, 32'h40000000, 32'hC0000000};
    run_batch("cancel", 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0); drain();
    ops = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h80000000,
            32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    run_batch("nar", 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0); drain();
    ops = '{8{32'h7FFFFFFF}};
    run_batch("maxpos", 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    ops = '{8{32'h00000001}};
    run_batch("minpos", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0); drain();
    ops = '{32'h40000000, 32'h38000000, 32'h40000000, 32'h38000000,
            32'h40000000, 32'h38000000, 32'h40000000, 32'h38000000};
    run_batch("six", 32'h54000000, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    ops = '{8{32'hC0000000}};
    run_batch("neg8", 32'hA8000000, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    ops = '{32'h40000000, 32'h40000000, 32'h40000000, 32'hC8000000,
            32'hC8000000, 32'hC8000000, 32'hC8000000, 32'hC8000000};
    run_batch("partial", 32'h38000000, 1'b0, 1'b0, 1'b0, 1'b0); drain();
    ops = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_batch("sticky", 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0); drain();

    // start held high: back-to-back batches every 10 cycles
    ops = '{8{32'h40000000}};
    for (int b = 0; b < 3; b++)
      run_batch($sformatf("held%0d", b), 32'h58000000, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // reset in the middle of a batch: no done, then a clean batch
    @(negedge clk);
    start = 1'b1; in_w = 32'h40000000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    d0 = dones;
    rst = 1'b0;
    @(negedge clk);
    check("midrst.result", result, 32'h0);
    check("midrst.zero", {31'b0, zero}, 32'h1);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst.no_done", dones, d0);
    ops = '{8{32'h40000000}};
    run_batch("post_rst", 32'h58000000, 1'b0, 1'b0, 1'b0, 1'b0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
